// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared states, event kinds and exception cause codes for trap_controller
package trap_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        ENTER  = 2'd2,
        RETURN = 2'd3
    } state_t;

    typedef enum logic {
        EV_TRAP = 1'b0,
        EV_MRET = 1'b1
    } ev_kind_t;

    localparam int unsigned CAUSE_ILLEGAL = 2;
    localparam int unsigned CAUSE_ECALL   = 11;

endpackage

// File: rtl/irq_priority_enc.sv
// rtl/irq_priority_enc.sv - lowest-index-wins encoder over enabled pending interrupt lines
module irq_priority_enc #(
    parameter int NUM_IRQ = 4,
    localparam int IDX_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan high to low so the last hit, the lowest index, is what remains.
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - interrupt/exception arbitration, flush sequencing and mie/mpie; IRQ_SYNC_EN adds a 2-flop ext_int synchronizer
module trap_controller
    import trap_pkg::*;
#(
    parameter int NUM_IRQ      = 4,
    parameter int CAUSE_W      = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] ext_int,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               inst_valid,
    input  logic               illegal,
    input  logic               ecall,
    input  logic               mret,
    input  logic               mie_we,
    input  logic               mie_wdata,
    output logic               flush,
    output logic               trap_req,
    output logic               mret_req,
    output logic [CAUSE_W-1:0] trap_cause,
    output logic               trap_is_int,
    output logic               mie,
    output logic               mpie,
    output logic               busy,
    output logic [NUM_IRQ-1:0] pending
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [2:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;

    state_t             state, state_nx;
    logic [2:0]         cnt, cnt_nx;
    ev_kind_t           lat_kind;
    logic [CAUSE_W-1:0] lat_cause;
    logic               lat_int;
    logic [IDX_W-1:0]   lat_idx;

    logic [NUM_IRQ-1:0] ext_s, ext_q, rise, pend_eff, irq_req, clr, pend_nx;
    logic [IDX_W-1:0]   irq_idx, take_idx;
    logic               irq_any, take_int;

    logic               accept;
    ev_kind_t           acc_kind;
    logic [CAUSE_W-1:0] acc_cause;
    logic               acc_int;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1, sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ext_int;
            sync2 <= sync1;
        end
    end

    assign ext_s = sync2;
`else
    assign ext_s = ext_int;
`endif

    // A fresh edge is arbitrated in the same cycle it is seen, not a cycle later.
    assign rise     = ext_s & ~ext_q;
    assign pend_eff = pending | rise;
    assign irq_req  = pend_eff & irq_mask;
    assign busy     = (state != RUN);

    irq_priority_enc #(.NUM_IRQ(NUM_IRQ)) u_irq_priority_enc (
        .req (irq_req),
        .idx (irq_idx),
        .any (irq_any)
    );

    always_comb begin
        accept    = 1'b0;
        acc_kind  = EV_TRAP;
        acc_cause = '0;
        acc_int   = 1'b0;
        if (state == RUN) begin
            if (mie && irq_any) begin
                accept    = 1'b1;
                acc_cause = CAUSE_W'(irq_idx);
                acc_int   = 1'b1;
            end else if (inst_valid && illegal) begin
                accept    = 1'b1;
                acc_cause = CAUSE_W'(CAUSE_ILLEGAL);
            end else if (inst_valid && ecall) begin
                accept    = 1'b1;
                acc_cause = CAUSE_W'(CAUSE_ECALL);
            end else if (inst_valid && mret) begin
                accept    = 1'b1;
                acc_kind  = EV_MRET;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        flush    = 1'b0;
        trap_req = 1'b0;
        mret_req = 1'b0;
        case (state)
            RUN: begin
                if (accept) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_nx = (acc_kind == EV_MRET) ? RETURN : ENTER;
                    end else begin
                        state_nx = FLUSH;
                        cnt_nx   = FLUSH_LOAD;
                    end
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (cnt == 3'd0) begin
                    state_nx = (lat_kind == EV_MRET) ? RETURN : ENTER;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            ENTER: begin
                trap_req = 1'b1;
                state_nx = RUN;
            end
            RETURN: begin
                mret_req = 1'b1;
                state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    // With no flush the taken edge and the entry share one clock, so that edge must not survive.
    assign take_int = (state == RUN) ? acc_int : lat_int;
    assign take_idx = (state == RUN) ? irq_idx : lat_idx;

    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr[i] = (state_nx == ENTER) && take_int && (take_idx == IDX_W'(i));
        end
        if (state == RUN) begin
            pend_nx = pend_eff & ~clr;
        end else begin
            pend_nx = (pending & ~clr) | rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            cnt         <= 3'd0;
            ext_q       <= '0;
            pending     <= '0;
            lat_kind    <= EV_TRAP;
            lat_cause   <= '0;
            lat_int     <= 1'b0;
            lat_idx     <= '0;
            trap_cause  <= '0;
            trap_is_int <= 1'b0;
            mie         <= 1'b0;
            mpie        <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ext_q   <= ext_s;
            pending <= pend_nx;
            if (accept) begin
                lat_kind  <= acc_kind;
                lat_cause <= acc_cause;
                lat_int   <= acc_int;
                lat_idx   <= irq_idx;
            end
            if (state_nx == ENTER) begin
                trap_cause  <= (state == RUN) ? acc_cause : lat_cause;
                trap_is_int <= take_int;
            end
            case (state)
                RUN: begin
                    if (mie_we && !accept) begin
                        mie <= mie_wdata;
                    end
                end
                ENTER: begin
                    mpie <= mie;
                    mie  <= 1'b0;
                end
                RETURN: begin
                    mie  <= mpie;
                    mpie <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - scoreboard bench for trap_controller (FLUSH_CYCLES=2 and 0 instances)
module tb_trap_controller;

`ifdef IRQ_SYNC_EN
    localparam int SYN = 2;
`else
    localparam int SYN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ext_int, irq_mask;
    logic       inst_valid, illegal, ecall, mret, mie_we, mie_wdata;

    logic       flush, trap_req, mret_req, trap_is_int, mie, mpie, busy;
    logic [3:0] trap_cause, pending;
    logic       z_flush, z_trap_req, z_mret_req, z_trap_is_int, z_mie, z_mpie, z_busy;
    logic [3:0] z_trap_cause, z_pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       is_mret;
        logic [3:0] cause;
        logic       is_int;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    trap_controller #(.NUM_IRQ(4), .CAUSE_W(4), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ext_int(ext_int), .irq_mask(irq_mask),
        .inst_valid(inst_valid), .illegal(illegal), .ecall(ecall), .mret(mret),
        .mie_we(mie_we), .mie_wdata(mie_wdata),
        .flush(flush), .trap_req(trap_req), .mret_req(mret_req), .trap_cause(trap_cause),
        .trap_is_int(trap_is_int), .mie(mie), .mpie(mpie), .busy(busy), .pending(pending)
    );

    trap_controller #(.NUM_IRQ(4), .CAUSE_W(4), .FLUSH_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ext_int(ext_int), .irq_mask(irq_mask),
        .inst_valid(inst_valid), .illegal(illegal), .ecall(ecall), .mret(mret),
        .mie_we(mie_we), .mie_wdata(mie_wdata),
        .flush(z_flush), .trap_req(z_trap_req), .mret_req(z_mret_req), .trap_cause(z_trap_cause),
        .trap_is_int(z_trap_is_int), .mie(z_mie), .mpie(z_mpie), .busy(z_busy), .pending(z_pending)
    );

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (trap_req || mret_req)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse trap_req=%0b mret_req=%0b cause=%0d", trap_req, mret_req, trap_cause);
            end else begin
                e = sb.pop_front();
                if ({mret_req, trap_req ? trap_cause : 4'd0, trap_req ? trap_is_int : 1'b0} !==
                    {e.is_mret, e.is_mret ? 4'd0 : e.cause, e.is_mret ? 1'b0 : e.is_int}) begin
                    errors++;
                    $display("FAIL sb_pulse got mret=%0b cause=%0d int=%0b want mret=%0b cause=%0d int=%0b",
                             mret_req, trap_cause, trap_is_int, e.is_mret, e.cause, e.is_int);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic m, input logic [3:0] c, input logic i);
        exp_t e;
        e.is_mret = m;
        e.cause   = c;
        e.is_int  = i;
        sb.push_back(e);
    endtask

    task automatic wait_pulse(input string nm);
        int n = 0;
        while (!(trap_req || mret_req) && n < 30) begin
            tick();
            n++;
        end
        chk(nm, 32'(n < 30), 32'd1);
    endtask

    task automatic write_mie(input logic v);
        mie_we = 1'b1;
        mie_wdata = v;
        tick();
        mie_we = 1'b0;
        mie_wdata = 1'b0;
    endtask

    task automatic do_mret();
        inst_valid = 1'b1;
        mret = 1'b1;
        tick();
        inst_valid = 1'b0;
        mret = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ext_int = '0; irq_mask = 4'hF;
        inst_valid = 0; illegal = 0; ecall = 0; mret = 0; mie_we = 0; mie_wdata = 0;
        repeat (3) tick();
        chk("reset_state", {flush, trap_req, mret_req, trap_is_int, mie, mpie, busy, pending, trap_cause}, 32'd0);
        rst_n = 1'b1;
        tick();

        // single interrupt on line 2, exact flush/pulse timing
        write_mie(1'b1);
        chk("mie_write", mie, 1);
        push_exp(0, 4'd2, 1);
        ext_int = 4'b0100;
        repeat (SYN) tick();
        tick(); chk("irq2_flush_c1", {flush, trap_req}, 2'b10);
        tick(); chk("irq2_flush_c2", {flush, trap_req}, 2'b10);
        tick(); chk("irq2_trap_req", {flush, trap_req}, 2'b01);
        tick(); chk("irq2_after", {mie, mpie, pending}, {1'b0, 1'b1, 4'b0000});
        ext_int = '0;

        // simultaneous lines 1 and 3: lowest first, 3 after mret
        write_mie(1'b1);
        push_exp(0, 4'd1, 1);
        ext_int = 4'b1010;
        wait_pulse("irq1_wait");
        tick();
        chk("irq1_after", {mie, pending}, {1'b0, 4'b1000});
        ext_int = '0;
        push_exp(1, 4'd0, 0);
        push_exp(0, 4'd3, 1);
        do_mret();
        wait_pulse("mret_wait");
        tick();
        wait_pulse("irq3_wait");
        tick();
        chk("irq3_after", {mie, mpie, pending}, {1'b0, 1'b1, 4'b0000});

        // illegal+ecall: gated by inst_valid, illegal wins
        illegal = 1'b1; ecall = 1'b1;
        tick();
        chk("no_valid_no_flush", {flush, busy}, 2'b00);
        push_exp(0, 4'd2, 0);
        inst_valid = 1'b1;
        tick();
        inst_valid = 0; illegal = 0; ecall = 0;
        chk("illegal_flush", flush, 1);
        wait_pulse("illegal_wait");
        tick();
        chk("cause_hold", {trap_cause, trap_is_int, mpie}, {4'd2, 1'b0, 1'b0});

        // mret timing from mie=0/mpie=1
        push_exp(1, 4'd0, 0);
        do_mret();
        wait_pulse("mret_prep_wait");
        tick();
        chk("mret_prep", {mie, mpie}, 2'b01);
        push_exp(1, 4'd0, 0);
        do_mret();
        chk("mret_flush_c1", flush, 1);
        tick(); chk("mret_flush_c2", flush, 1);
        tick(); chk("mret_req_pulse", {flush, mret_req}, 2'b01);
        tick(); chk("mret_after", {mie, mpie}, 2'b11);

        // interrupt edge and mie write while busy on ecall
        write_mie(1'b0);
        push_exp(0, 4'd11, 0);
        inst_valid = 1'b1; ecall = 1'b1;
        tick();
        inst_valid = 0; ecall = 0;
        ext_int = 4'b0001;
        mie_we = 1'b1; mie_wdata = 1'b1;
        tick();
        mie_we = 1'b0; mie_wdata = 1'b0;
        wait_pulse("ecall_wait");
        tick();
        chk("busy_irq_pending", {mie, pending}, {1'b0, 4'b0001});
        push_exp(1, 4'd0, 0);
        do_mret();
        wait_pulse("mret_busy_wait");
        tick();
        chk("irq0_still_pending", {mie, pending, busy}, {1'b0, 4'b0001, 1'b0});
        push_exp(0, 4'd0, 1);
        write_mie(1'b1);
        wait_pulse("irq0_wait");
        tick();
        chk("irq0_cleared", pending, 4'b0000);
        ext_int = '0;

        // reset in the middle of a flush
        inst_valid = 1'b1; ecall = 1'b1;
        tick();
        inst_valid = 0; ecall = 0;
        chk("pre_reset_flush", flush, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {flush, trap_req, mret_req, trap_is_int, mie, mpie, busy, pending, trap_cause,
                            z_mie, z_busy, z_pending}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("no_trap_after_reset", {busy, flush}, 2'b00);

        // zero-flush instance: pulse right after acceptance
        push_exp(0, 4'd2, 0);
        inst_valid = 1'b1; illegal = 1'b1;
        tick();
        inst_valid = 0; illegal = 0;
        chk("z_illegal", {z_trap_req, z_flush, z_trap_cause, z_trap_is_int}, {1'b1, 1'b0, 4'd2, 1'b0});
        wait_pulse("illegal2_wait");
        tick();
        write_mie(1'b1);
        push_exp(0, 4'd1, 1);
        ext_int = 4'b0010;
        repeat (SYN) tick();
        tick();
        chk("z_irq1", {z_trap_req, z_flush, z_trap_cause, z_trap_is_int}, {1'b1, 1'b0, 4'd1, 1'b1});
        tick();
        chk("z_irq1_after", {z_pending, z_busy, z_mie}, {4'b0000, 1'b0, 1'b0});
        wait_pulse("irq1b_wait");
        tick();
        ext_int = '0;
        repeat (3) tick();

        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Sequential, parametrised successor to the combinational interrupt-cause logic in the control unit.
- Latches NUM_IRQ external interrupt lines and arbitrates them against decoder exceptions (illegal, ecall) and mret.
- Sequences a pipeline flush, then issues a one-cycle trap-entry or trap-return pulse to the PC/CSR datapath.
- Holds the machine-level global interrupt enable (mie) and its previous value (mpie).

Parameters:
- NUM_IRQ, 4: number of external interrupt lines, 1..16.
- CAUSE_W, 4: width of trap_cause; must be >= max(4, clog2(NUM_IRQ)).
- FLUSH_CYCLES, 2: cycles flush is held before the pulse, 0..7.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ext_int  in  NUM_IRQ  level interrupt lines; a rising edge marks an interrupt pending.
- irq_mask  in  NUM_IRQ  per-line enable; 1 = enabled.
- inst_valid  in  1  decoder outputs are valid this cycle.
- illegal  in  1  illegal instruction (qualified by inst_valid).
- ecall  in  1  ecall instruction (qualified by inst_valid).
- mret  in  1  mret instruction (qualified by inst_valid).
- mie_we  in  1  CSR write strobe for mie.
- mie_wdata  in  1  CSR write data for mie.
- flush  out  1  pipeline flush request.
- trap_req  out  1  one-cycle trap entry pulse.
- mret_req  out  1  one-cycle trap return pulse.
- trap_cause  out  CAUSE_W  cause code, valid while trap_req is high.
- trap_is_int  out  1  1 = interrupt, 0 = exception; valid with trap_req.
- mie  out  1  global interrupt enable.
- mpie  out  1  saved interrupt enable.
- busy  out  1  state != RUN.
- pending  out  NUM_IRQ  pending-interrupt register.

Behaviour:
- Reset (async, rst_n low): state=RUN, all outputs 0. This includes mie=0, mpie=0, pending=0, and the edge-detect history. Asserting reset mid-sequence aborts the sequence immediately; no pulse is emitted.
- Edge detect: pending[i] sets at a clock edge where ext_int[i]=1 and the previous sample was 0. pending[i] clears when line i is taken. If a new edge arrives in the same cycle line i is taken, set wins.
- Arbitration happens only in RUN, evaluated each cycle. Priority order:
  - (1) Interrupt: mie=1 and (pending & irq_mask) != 0. The lowest index wins. cause=index, is_int=1.
  - (2) illegal & inst_valid: cause=2, is_int=0.
  - (3) ecall & inst_valid: cause=11, is_int=0.
  - (4) mret & inst_valid: return path.
- FSM states: RUN, FLUSH, ENTER, RETURN.
  - RUN: when an event is accepted, latch kind/cause. Go to FLUSH, or directly to ENTER/RETURN if FLUSH_CYCLES=0.
  - FLUSH: flush=1 for exactly FLUSH_CYCLES cycles (down-counter). Then go to ENTER (trap) or RETURN (mret).
  - ENTER: trap_req=1 for one cycle with the latched trap_cause/trap_is_int. mpie<=mie, mie<=0. The taken pending bit clears on entry to ENTER. Next state RUN.
  - RETURN: mret_req=1 for one cycle. mie<=mpie, mpie<=1. Next state RUN.
- Latency: for an interrupt edge sampled at edge k, flush is high over cycles k+1..k+FLUSH_CYCLES and trap_req is high in cycle k+FLUSH_CYCLES+1. A decoder exception accepted at edge k has the same timing.
- While busy: decoder inputs are ignored, edges still set pending, and mie_we is ignored.
- In RUN, mie_we writes mie. If mie_we and an event coincide, the event is arbitrated using the old mie, and the write is dropped when the event is accepted.
- trap_cause and trap_is_int hold their last value outside ENTER.

Optional Feature:
- IRQ_SYNC_EN defined: ext_int passes through a 2-flop synchronizer (reset to 0) before edge detection, adding exactly 2 cycles to interrupt latency.
- Undefined: ext_int is sampled directly and is assumed synchronous to clk.

Decomposition:
- Package trap_pkg holds:
  - state enum {RUN, FLUSH, ENTER, RETURN}.
  - CAUSE_ILLEGAL=2 and CAUSE_ECALL=11.
  - Event-kind enum {EV_TRAP, EV_MRET}.
- One sub-module, irq_priority_enc: combinational, NUM_IRQ-parameterised. Takes pending & irq_mask; outputs idx[clog2(NUM_IRQ)-1:0] and any.

Test Plan:
- Reset then mie_we=1/mie_wdata=1; pulse ext_int[2] at edge 10 -> flush high cycles 11–12, trap_req in cycle 13 with cause=2, is_int=1; then mie=0, mpie=1, pending[2]=0.
- ext_int[1] and ext_int[3] rise together with both unmasked and mie=1 -> cause=1 first. After mret and re-enable, cause=3 is taken.
- illegal and ecall both high with inst_valid=1 and mie=0 -> trap_req with cause=2, is_int=0. Same stimulus with inst_valid=0 -> no flush.
- From mie=0, mpie=1: mret with inst_valid=1 -> flush for 2 cycles, mret_req pulse, then mie=1, mpie=1.
- Interrupt edge while busy on an ecall -> ecall trap is issued first; the interrupt is still pending but not taken (mie=0) until mret.
- rst_n low during FLUSH -> all outputs 0 immediately; no trap_req after release. Repeat with FLUSH_CYCLES=0 and with IRQ_SYNC_EN defined (latency +2).
